// File: rtl/miner_work_ctrl.sv
`timescale 1ns/1ps
// miner_work_ctrl
//   Sequences the double-SHA-256 hasher pair. It latches work from the MIPI RX
//   path and generates nonce/cnt/feedback for the loop-folded transforms. It
//   qualifies golden tickets from the second transform, then buffers the found
//   nonces in a small FIFO. The FIFO drains to the MIPI TX path over a
//   send/busy handshake.
//
// Ports
//   hash_clk, reset            clock, asynchronous active-high reset
//   work_valid                 1-cycle pulse: new work on work_midstate/work_data
//   work_midstate[255:0]       midstate for the first transform
//   work_data[127:0]           block-2 header tail, only [95:0] used
//   hash2_top[31:0]            hash2[255:224] from the second transform
//   hasher_state[255:0]        rx_state to the first transform
//   hasher_data[511:0]         {padding, nonce, data[95:0]}
//   hasher_cnt[5:0]            round-group counter to both transforms
//   hasher_feedback            feedback select to both transforms
//   result_send/result_nonce   FIFO head presented to TX
//   result_busy                TX busy, used as the acknowledge
//   running, exhausted         FSM status (RUN / DONE)
//   overflow                   sticky: a golden nonce was dropped on a full FIFO
//
// States
//   S_IDLE  | waiting for first work, nothing issued
//   S_RUN   | issuing nonces into the hasher pipeline
//   S_DRAIN | last nonce issued, still detecting in-flight hashes
//   S_DONE  | full 2^32 range searched, waiting for new work
module miner_work_ctrl #(
  parameter int unsigned LOOP_LOG2       = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         work_valid,
  input  logic [255:0] work_midstate,
  input  logic [127:0] work_data,
  input  logic [31:0]  hash2_top,
  output logic [255:0] hasher_state,
  output logic [511:0] hasher_data,
  output logic [5:0]   hasher_cnt,
  output logic         hasher_feedback,
  output logic         result_send,
  output logic [31:0]  result_nonce,
  input  logic         result_busy,
  output logic         running,
  output logic         exhausted,
  output logic         overflow
);

  localparam int unsigned LOOP   = 1 << LOOP_LOG2;
  // Pipeline depth from nonce issue to hash2_top, in clocks.
  localparam int unsigned OFFSET = (LOOP_LOG2 == 0) ? 131 :
                                   (LOOP_LOG2 == 1) ? 66  :
                                   (1 << (7 - LOOP_LOG2)) + 1;
  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2 + 1;

  localparam logic [5:0]   CNT_MASK  = 6'(LOOP - 1);
  localparam logic [7:0]   OFFSET_C  = 8'(OFFSET);
  localparam logic [31:0]  OFFSET_32 = 32'(OFFSET);
  localparam logic [383:0] PAD       = {32'h0000_0280, 320'd0, 32'h8000_0000};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [5:0]     cnt_q, cnt_d, cnt_step;
  logic           fb_q, fb_d;
  logic [7:0]     flush_q, flush_d;
  logic [7:0]     drain_q, drain_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [95:0]    data_q, data_d;
  logic [255:0]   hasher_state_q;
  logic [511:0]   hasher_data_q;
  logic           running_q, exhausted_q;

  logic           fb_d1_q;
  logic           golden_q, golden_d;
  logic           detect_en;

  logic [31:0]    fifo_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic           fifo_empty, fifo_full;
  logic           hold_q, hold_d;
  logic           overflow_q;
  logic           push, pop, drop;
  logic [31:0]    push_nonce;

  logic           unused_work_bits;
  assign unused_work_bits = ^work_data[127:96];

  // Sequencer next-state
  always_comb begin
    state_d    = state_q;
    nonce_d    = nonce_q;
    cnt_d      = cnt_q;
    fb_d       = fb_q;
    drain_d    = drain_q;
    midstate_d = midstate_q;
    data_d     = data_q;
    cnt_step   = (cnt_q + 6'd1) & CNT_MASK;
    flush_d    = (flush_q != 8'd0) ? flush_q - 8'd1 : flush_q;

    if (work_valid) begin
      midstate_d = work_midstate;
      data_d     = work_data[95:0];
      nonce_d    = '0;
      cnt_d      = '0;
      fb_d       = 1'b0;
      drain_d    = '0;
      flush_d    = OFFSET_C;
      state_d    = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          nonce_d = '0;
          cnt_d   = '0;
          fb_d    = 1'b0;
        end
        S_RUN: begin
          if (cnt_step == 6'd0) begin
            cnt_d = '0;
            fb_d  = 1'b0;
            // Last nonce already issued: stop rather than wrap.
            if (nonce_q == 32'hFFFF_FFFF) begin
              state_d = S_DRAIN;
              drain_d = OFFSET_C - 8'd1;
            end else begin
              nonce_d = nonce_q + 32'd1;
            end
          end else begin
            cnt_d = cnt_step;
            fb_d  = 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == 8'd0) state_d = S_DONE;
          else                 drain_d = drain_q - 8'd1;
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      nonce_q        <= '0;
      cnt_q          <= '0;
      fb_q           <= 1'b0;
      flush_q        <= '0;
      drain_q        <= '0;
      midstate_q     <= '0;
      data_q         <= '0;
      hasher_state_q <= '0;
      hasher_data_q  <= '0;
      running_q      <= 1'b0;
      exhausted_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      nonce_q        <= nonce_d;
      cnt_q          <= cnt_d;
      fb_q           <= fb_d;
      flush_q        <= flush_d;
      drain_q        <= drain_d;
      midstate_q     <= midstate_d;
      data_q         <= data_d;
      // Built from next-state values so the words line up with nonce_q.
      hasher_state_q <= midstate_d;
      hasher_data_q  <= {PAD, nonce_d, data_d};
      running_q      <= (state_d == S_RUN);
      exhausted_q    <= (state_d == S_DONE);
    end
  end

  // Detection: the work_valid cycle is excluded because a hit seen then would be
  // pushed against the already-cleared nonce.
  assign detect_en = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     (flush_q == 8'd0) && !work_valid;
  assign golden_d  = (hash2_top == 32'd0) && !fb_d1_q && detect_en;

  // Result FIFO
  assign wr_idx     = wr_ptr_q[FIFO_DEPTH_LOG2-1:0];
  assign rd_idx     = rd_ptr_q[FIFO_DEPTH_LOG2-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

  // hold_q masks the head after a pop until busy drops, so one busy pulse
  // acknowledges exactly one word.
  assign result_send  = !fifo_empty && !hold_q;
  assign result_nonce = fifo_empty ? 32'd0 : fifo_mem_q[rd_idx];

  assign pop        = result_send && result_busy;
  assign push       = golden_q && (!fifo_full || pop);
  assign drop       = golden_q && fifo_full && !pop;
  assign push_nonce = nonce_q - OFFSET_32;
  assign hold_d     = pop || (hold_q && result_busy);

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      fb_d1_q    <= 1'b0;
      golden_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      fb_d1_q  <= fb_q;
      golden_q <= golden_d;
      hold_q   <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) fifo_mem_q[wr_idx] <= push_nonce;
  end

  assign hasher_state    = hasher_state_q;
  assign hasher_data     = hasher_data_q;
  assign hasher_cnt      = cnt_q;
  assign hasher_feedback = fb_q;
  assign running         = running_q;
  assign exhausted       = exhausted_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_miner_work_ctrl.sv
`timescale 1ns/1ps
module tb_miner_work_ctrl;

  logic         hash_clk;
  logic         reset;
  logic         work_valid;
  logic [255:0] work_midstate;
  logic [127:0] work_data;
  logic [31:0]  hash2_top;
  logic [255:0] hasher_state;
  logic [511:0] hasher_data;
  logic [5:0]   hasher_cnt;
  logic         hasher_feedback;
  logic         result_send;
  logic [31:0]  result_nonce;
  logic         result_busy;
  logic         running;
  logic         exhausted;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [255:0] m1, m2;
  logic [127:0] d1, d2;
  int           n;

  miner_work_ctrl #(.LOOP_LOG2(1), .FIFO_DEPTH_LOG2(2)) dut (
    .hash_clk        (hash_clk),
    .reset           (reset),
    .work_valid      (work_valid),
    .work_midstate   (work_midstate),
    .work_data       (work_data),
    .hash2_top       (hash2_top),
    .hasher_state    (hasher_state),
    .hasher_data     (hasher_data),
    .hasher_cnt      (hasher_cnt),
    .hasher_feedback (hasher_feedback),
    .result_send     (result_send),
    .result_nonce    (result_nonce),
    .result_busy     (result_busy),
    .running         (running),
    .exhausted       (exhausted),
    .overflow        (overflow)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic tick_n(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  // One busy pulse: head must match, then one word is acknowledged.
  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check_eq({tag, "_send"}, 128'(result_send), 128'd1);
    check_eq({tag, "_nonce"}, 128'(result_nonce), 128'(exp));
    result_busy = 1'b1;
    tick();
    result_busy = 1'b0;
    tick();
  endtask

  initial begin
    m1 = {4{64'h0123_4567_89ab_cdef}};
    m2 = {4{64'hfeed_face_cafe_babe}};
    d1 = 128'hdead_beef_0011_2233_4455_6677_8899_aabb;
    d2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    reset         = 1'b1;
    work_valid    = 1'b0;
    work_midstate = '0;
    work_data     = '0;
    hash2_top     = 32'h1234_5678;
    result_busy   = 1'b0;
    tick_n(3);

    check_eq("rst_running",  128'(running), 128'd0);
    check_eq("rst_exhaust",  128'(exhausted), 128'd0);
    check_eq("rst_overflow", 128'(overflow), 128'd0);
    check_eq("rst_send",     128'(result_send), 128'd0);
    check_eq("rst_nonce",    128'(result_nonce), 128'd0);
    check_eq("rst_cnt",      128'(hasher_cnt), 128'd0);
    check_eq("rst_fb",       128'(hasher_feedback), 128'd0);
    check_eq("rst_data_lo",  hasher_data[127:0], 128'd0);
    check_eq("rst_data_hi",  hasher_data[511:384], 128'd0);
    check_eq("rst_state",    hasher_state[255:128], 128'd0);

    reset = 1'b0;
    tick_n(2);
    check_eq("idle_running", 128'(running), 128'd0);
    check_eq("idle_cnt",     128'(hasher_cnt), 128'd0);

    // First work: c1 is the cycle right after the work_valid edge.
    work_midstate = m1;
    work_data     = d1;
    work_valid    = 1'b1;
    tick();
    work_valid = 1'b0;
    check_eq("c1_running",  128'(running), 128'd1);
    check_eq("c1_state",    hasher_state[255:128], m1[255:128]);
    check_eq("c1_state_lo", hasher_state[127:0], m1[127:0]);
    check_eq("c1_data_lo",  hasher_data[127:0], {32'h0, d1[95:0]});
    check_eq("c1_pad_hi",   128'(hasher_data[511:480]), 128'h280);
    check_eq("c1_pad_lo",   128'(hasher_data[159:128]), 128'h8000_0000);
    check_eq("c1_cnt",      128'(hasher_cnt), 128'd0);
    check_eq("c1_fb",       128'(hasher_feedback), 128'd0);
    tick();
    check_eq("c2_cnt",   128'(hasher_cnt), 128'd1);
    check_eq("c2_fb",    128'(hasher_feedback), 128'd1);
    check_eq("c2_nonce", 128'(hasher_data[127:96]), 128'd0);
    tick();
    check_eq("c3_cnt",   128'(hasher_cnt), 128'd0);
    check_eq("c3_nonce", 128'(hasher_data[127:96]), 128'd1);

    // Last flush cycle is c66: a hit there must be ignored.
    tick_n(63);
    hash2_top = 32'd0;
    tick();
    hash2_top = 32'h1;
    tick();
    check_eq("flush_nopush", 128'(result_send), 128'd0);
    // c68: first !feedback_d1 cycle after flush, nonce 34 at push.
    hash2_top = 32'd0;
    tick();
    check_eq("c69_send_early", 128'(result_send), 128'd0);
    // c69 keeps hash2_top=0 but feedback_d1=1: no push.
    tick();
    hash2_top = 32'h1;
    check_eq("c70_send",  128'(result_send), 128'd1);
    check_eq("c70_nonce", 128'(result_nonce), 128'hFFFF_FFE0);
    result_busy = 1'b1;
    tick();
    check_eq("c71_popped", 128'(result_send), 128'd0);
    result_busy = 1'b0;
    tick();
    check_eq("fb_nopush", 128'(result_send), 128'd0);

    // Five hits at c72..c80 (even cycles) with busy low; the fifth is dropped.
    hash2_top = 32'd0;
    tick_n(8);
    check_eq("c80_ovf", 128'(overflow), 128'd0);
    tick();
    hash2_top = 32'h1;
    check_eq("c81_ovf", 128'(overflow), 128'd0);
    tick();
    check_eq("c82_ovf",   128'(overflow), 128'd1);
    check_eq("c82_send",  128'(result_send), 128'd1);
    check_eq("c82_head",  128'(result_nonce), 128'hFFFF_FFE2);

    // Busy held high acknowledges one word only.
    result_busy = 1'b1;
    tick();
    check_eq("c83_hold", 128'(result_send), 128'd0);
    tick();
    check_eq("c84_hold", 128'(result_send), 128'd0);
    result_busy = 1'b0;
    tick();
    check_eq("c85_send", 128'(result_send), 128'd1);
    check_eq("c85_head", 128'(result_nonce), 128'hFFFF_FFE3);

    // c86 hit fills the FIFO; c88 hit is pushed in the same cycle as a pop.
    tick();
    hash2_top = 32'd0;
    tick();
    hash2_top = 32'h1;
    tick();
    hash2_top = 32'd0;
    check_eq("c88_head", 128'(result_nonce), 128'hFFFF_FFE3);
    tick();
    hash2_top = 32'h1;
    result_busy = 1'b1;
    tick();
    result_busy = 1'b0;
    check_eq("c90_hold", 128'(result_send), 128'd0);
    tick();
    pop_expect("q0", 32'hFFFF_FFE4);
    pop_expect("q1", 32'hFFFF_FFE5);
    pop_expect("q2", 32'hFFFF_FFE9);
    check_eq("full_pushpop", 128'(result_nonce), 128'hFFFF_FFEA);

    // Second work with hash2_top=0 across the whole flush window.
    work_midstate = m2;
    work_data     = d2;
    work_valid    = 1'b1;
    hash2_top     = 32'd0;
    tick();
    work_valid = 1'b0;
    check_eq("w2_nonce",   128'(hasher_data[127:96]), 128'd0);
    check_eq("w2_state",   hasher_state[255:128], m2[255:128]);
    check_eq("w2_data",    128'(hasher_data[95:0]), 128'(d2[95:0]));
    check_eq("w2_ovf",     128'(overflow), 128'd1);
    check_eq("w2_kept",    128'(result_nonce), 128'hFFFF_FFEA);
    tick_n(65);
    tick();
    hash2_top = 32'h1;
    tick();
    pop_expect("w2_q", 32'hFFFF_FFEA);
    check_eq("w2_flush_nopush", 128'(result_send), 128'd0);

    // Near the top of the range: finish, drain for 66 cycles, then DONE.
    force dut.nonce_q = 32'hFFFF_FFF0;
    #1;
    release dut.nonce_q;
    n = 0;
    while (running && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_entry", 128'(running), 128'd0);
    n = 0;
    while (!exhausted && n < 200) begin
      check_eq("drain_nonce", 128'(hasher_data[127:96]), 128'hFFFF_FFFF);
      tick();
      n++;
    end
    check_eq("drain_len",   128'(n), 128'd66);
    check_eq("done_exh",    128'(exhausted), 128'd1);
    check_eq("done_run",    128'(running), 128'd0);
    tick_n(3);
    check_eq("done_hold",   128'(exhausted), 128'd1);
    check_eq("done_nonce",  128'(hasher_data[127:96]), 128'hFFFF_FFFF);
    check_eq("done_cnt",    128'(hasher_cnt), 128'd0);

    // New work from DONE restarts the search.
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
    check_eq("restart_run",   128'(running), 128'd1);
    check_eq("restart_exh",   128'(exhausted), 128'd0);
    check_eq("restart_nonce", 128'(hasher_data[127:96]), 128'd0);
    tick_n(5);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_run",  128'(running), 128'd0);
    check_eq("arst_ovf",  128'(overflow), 128'd0);
    check_eq("arst_data", hasher_data[127:0], 128'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
